bc_sync_fifo: RTL and testbench

BC_SYNC_FIFO -- requirements
Module: bc_sync_fifo

---
 rtl/bc_sync_fifo_if.sv | 36 +++
 rtl/bc_sync_fifo.sv | 94 +++++++++
 tb/tb_bc_sync_fifo.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/bc_sync_fifo_if.sv
// rtl/bc_sync_fifo_if.sv - data/status bundle between a FIFO user and bc_sync_fifo
//
// Signals:
//   wr     write request                      (master -> slave)
//   di     write data, WIDTH bits             (master -> slave)
//   rd     read request / head acknowledge    (master -> slave)
//   dout   head-of-queue word, show-ahead     (slave -> master)
//   full, empty, afull, aempty                occupancy flags (slave -> master)
//   cnt    occupancy 0..2**AW, AW+1 bits      (slave -> master)
//   ovf, udf                                  sticky overflow/underflow (slave -> master)
interface bc_sync_fifo_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
);
    logic             wr;
    logic [WIDTH-1:0] di;
    logic             rd;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic             afull;
    logic             aempty;
    logic [AW:0]      cnt;
    logic             ovf;
    logic             udf;

    modport master (
        output wr, di, rd,
        input  dout, full, empty, afull, aempty, cnt, ovf, udf
    );

    modport slave (
        input  wr, di, rd,
        output dout, full, empty, afull, aempty, cnt, ovf, udf
    );
endinterface

// File: rtl/bc_sync_fifo.sv
// rtl/bc_sync_fifo.sv - single-clock show-ahead FIFO with LUT-RAM storage
//
// Ports:
//   clk  rising-edge clock for all state
//   rst  synchronous active-high reset (clears pointers, count, sticky flags)
//   clr  synchronous flush (clears pointers and count, keeps sticky flags)
//   bus  bc_sync_fifo_if.slave: wr/di/rd in; dout/full/empty/afull/aempty/cnt/ovf/udf out
module bc_sync_fifo #(
    parameter int WIDTH  = 8,
    parameter int AW     = 4,
    parameter int AF_LVL = 2**AW - 2,
    parameter int AE_LVL = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    bc_sync_fifo_if.slave      bus
);
    localparam int          DEPTH    = 2**AW;
    localparam logic [AW:0] C_DEPTH  = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_AF_LVL = (AW+1)'(AF_LVL);
    localparam logic [AW:0] C_AE_LVL = (AW+1)'(AE_LVL);

    if (AF_LVL < 0 || AF_LVL > DEPTH || AE_LVL < 0 || AE_LVL >= DEPTH) begin : g_param_err
        $error("bc_sync_fifo: AF_LVL must be in 0..2**AW and AE_LVL in 0..2**AW-1");
    end

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;
    logic             r_ovf;
    logic             r_udf;

    logic w_full;
    logic w_empty;
    logic w_rd_acc;
    logic w_wr_acc;

    // Flags decode only the registered count, so there is no path from wr/rd.
    assign w_full   = (r_cnt == C_DEPTH);
    assign w_empty  = (r_cnt == '0);
    assign w_rd_acc = bus.rd & ~w_empty;
    // A read in the same cycle frees the slot, so a write into a full FIFO is fine then.
    assign w_wr_acc = bus.wr & (~w_full | w_rd_acc);

    // Storage is never reset; a write during rst/clr is dropped.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !rst && !clr) begin
            r_mem[r_wp] <= bus.di;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (clr) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_rd_acc) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (bus.wr && w_full && !w_rd_acc) begin
                r_ovf <= 1'b1;
            end
            if (bus.rd && w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign bus.dout   = r_mem[r_rp];
    assign bus.cnt    = r_cnt;
    assign bus.full   = w_full;
    assign bus.empty  = w_empty;
    assign bus.afull  = (r_cnt >= C_AF_LVL);
    assign bus.aempty = (r_cnt <= C_AE_LVL);
    assign bus.ovf    = r_ovf;
    assign bus.udf    = r_udf;
endmodule

// File: tb/tb_bc_sync_fifo.sv
// tb/tb_bc_sync_fifo.sv - self-checking bench for bc_sync_fifo against a queue model
module tb_bc_sync_fifo;
    localparam int WIDTH = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic clk;
    logic rst;
    logic clr;

    bc_sync_fifo_if #(.WIDTH(WIDTH), .AW(AW)) bus();

    bc_sync_fifo #(.WIDTH(WIDTH), .AW(AW), .AF_LVL(AF), .AE_LVL(AE)) u_dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain queue of words plus sticky bits and a read-slot tracker.
    logic [7:0] mq[$];
    bit         m_ovf = 0;
    bit         m_udf = 0;
    int         m_rslot = 0;
    int         m_wraps = 0;

    task automatic step(input logic w, input logic [7:0] d, input logic r,
                        input logic c, input logic rs);
        int n;
        bit racc;
        bit wacc;
        n = mq.size();
        bus.wr = w; bus.di = d; bus.rd = r; clr = c; rst = rs;
        if (rs) begin
            mq.delete(); m_ovf = 0; m_udf = 0; m_rslot = 0;
        end else if (c) begin
            mq.delete(); m_rslot = 0;
        end else begin
            racc = r && (n > 0);
            wacc = w && ((n < DEPTH) || racc);
            if (w && n == DEPTH && !racc) m_ovf = 1;
            if (r && n == 0) m_udf = 1;
            if (racc) begin
                void'(mq.pop_front());
                m_rslot = m_rslot + 1;
                if (m_rslot == DEPTH) begin
                    m_rslot = 0;
                    m_wraps = m_wraps + 1;
                end
            end
            if (wacc) mq.push_back(d);
        end
        @(posedge clk);
        #1;
        bus.wr = 1'b0; bus.rd = 1'b0; clr = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset;
        step(0, 8'h00, 0, 0, 1);
        n_checks++; if (bus.cnt !== 5'd0)  begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", bus.cnt); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
        n_checks++; if (bus.aempty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty: got %b expected 1", bus.aempty); end
        n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", bus.full); end
        n_checks++; if (bus.afull !== 1'b0) begin n_fail++; $display("FAIL reset_afull: got %b expected 0", bus.afull); end
        n_checks++; if (bus.ovf !== 1'b0 || bus.udf !== 1'b0) begin n_fail++; $display("FAIL reset_sticky: got ovf=%b udf=%b expected 0 0", bus.ovf, bus.udf); end
    endtask

    task automatic test_fill;
        step(0, 8'h00, 0, 0, 1);
        for (int k = 1; k <= DEPTH; k++) begin
            step(1, 8'(k), 0, 0, 0);
            n_checks++;
            if (bus.cnt !== 5'(k) || bus.afull !== (k >= AF) || bus.aempty !== (k <= AE)) begin
                n_fail++;
                $display("FAIL fill_step%0d: got cnt=%0d afull=%b aempty=%b expected cnt=%0d afull=%b aempty=%b",
                         k, bus.cnt, bus.afull, bus.aempty, k, k >= AF, k <= AE);
            end
        end
        n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b expected 1", bus.full); end
        n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL fill_ovf: got %b expected 0", bus.ovf); end
    endtask

    task automatic test_overflow;
        step(1, 8'hAA, 0, 0, 0);
        n_checks++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", bus.ovf); end
        n_checks++; if (bus.cnt !== 5'd16) begin n_fail++; $display("FAIL ovf_cnt: got %0d expected 16", bus.cnt); end
        for (int k = 1; k <= DEPTH; k++) begin
            n_checks++;
            if (bus.dout !== 8'(k)) begin n_fail++; $display("FAIL ovf_read%0d: got %0h expected %0h", k, bus.dout, k); end
            step(0, 8'h00, 1, 0, 0);
        end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drained: got empty=%b expected 1", bus.empty); end
        n_checks++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", bus.ovf); end
    endtask

    task automatic test_full_rdwr;
        logic [7:0] exp_v;
        step(0, 8'h00, 0, 0, 1);
        for (int k = 1; k <= DEPTH; k++) step(1, 8'(k), 0, 0, 0);
        step(1, 8'h55, 1, 0, 0);
        n_checks++; if (bus.cnt !== 5'd16 || bus.full !== 1'b1) begin n_fail++; $display("FAIL fullrw_cnt: got cnt=%0d full=%b expected 16 1", bus.cnt, bus.full); end
        n_checks++; if (bus.dout !== 8'h02) begin n_fail++; $display("FAIL fullrw_head: got %0h expected 02", bus.dout); end
        n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL fullrw_ovf: got %b expected 0", bus.ovf); end
        for (int k = 0; k < DEPTH; k++) begin
            exp_v = (k == DEPTH - 1) ? 8'h55 : 8'(k + 2);
            n_checks++;
            if (bus.dout !== exp_v) begin n_fail++; $display("FAIL fullrw_read%0d: got %0h expected %0h", k, bus.dout, exp_v); end
            step(0, 8'h00, 1, 0, 0);
        end
    endtask

    task automatic test_empty_rdwr;
        n_checks++; if (bus.empty !== 1'b1 || bus.udf !== 1'b0) begin n_fail++; $display("FAIL emptyrw_pre: got empty=%b udf=%b expected 1 0", bus.empty, bus.udf); end
        step(1, 8'h33, 1, 0, 0);
        n_checks++; if (bus.udf !== 1'b1) begin n_fail++; $display("FAIL emptyrw_udf: got %b expected 1", bus.udf); end
        n_checks++; if (bus.empty !== 1'b0 || bus.cnt !== 5'd1) begin n_fail++; $display("FAIL emptyrw_cnt: got empty=%b cnt=%0d expected 0 1", bus.empty, bus.cnt); end
        n_checks++; if (bus.dout !== 8'h33) begin n_fail++; $display("FAIL emptyrw_dout: got %0h expected 33", bus.dout); end
    endtask

    task automatic test_clear;
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 1, 0, 0);
        for (int k = 0; k < 7; k++) step(1, 8'(8'h40 + k), 0, 0, 0);
        n_checks++; if (bus.cnt !== 5'd7) begin n_fail++; $display("FAIL clr_pre_cnt: got %0d expected 7", bus.cnt); end
        step(1, 8'hEE, 0, 1, 0);
        n_checks++; if (bus.cnt !== 5'd0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL clr_cnt: got cnt=%0d empty=%b expected 0 1", bus.cnt, bus.empty); end
        n_checks++; if (bus.udf !== 1'b1 || bus.ovf !== 1'b0) begin n_fail++; $display("FAIL clr_sticky: got ovf=%b udf=%b expected 0 1", bus.ovf, bus.udf); end
        step(1, 8'h77, 0, 0, 0);
        n_checks++; if (bus.dout !== 8'h77 || bus.cnt !== 5'd1) begin n_fail++; $display("FAIL clr_after_write: got dout=%0h cnt=%0d expected 77 1", bus.dout, bus.cnt); end
    endtask

    task automatic test_random;
        int wr_pct;
        int rd_pct;
        int n;
        int prints = 0;
        logic w;
        logic r;
        logic c;
        step(0, 8'h00, 0, 0, 1);
        m_wraps = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if ((cyc / 400) % 2 == 0) begin wr_pct = 75; rd_pct = 40; end
            else                      begin wr_pct = 40; rd_pct = 75; end
            w = ($urandom_range(0, 99) < wr_pct);
            r = ($urandom_range(0, 99) < rd_pct);
            c = ($urandom_range(0, 499) == 0);
            step(w, 8'($urandom), r, c, 0);
            n = mq.size();
            n_checks++;
            if (bus.cnt !== 5'(n) || bus.empty !== (n == 0) || bus.full !== (n == DEPTH) ||
                bus.afull !== (n >= AF) || bus.aempty !== (n <= AE) ||
                bus.ovf !== m_ovf || bus.udf !== m_udf || (n > 0 && bus.dout !== mq[0])) begin
                n_fail++;
                if (prints < 20) begin
                    prints++;
                    $display("FAIL random_cyc%0d: got cnt=%0d e=%b f=%b af=%b ae=%b ovf=%b udf=%b dout=%0h expected cnt=%0d ovf=%b udf=%b dout=%0h",
                             cyc, bus.cnt, bus.empty, bus.full, bus.afull, bus.aempty, bus.ovf, bus.udf,
                             bus.dout, n, m_ovf, m_udf, (n > 0) ? mq[0] : 8'h00);
                end
            end
        end
        n_checks++;
        if (m_wraps < 100) begin n_fail++; $display("FAIL random_wraps: got %0d expected >= 100", m_wraps); end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0;
        bus.wr = 1'b0; bus.rd = 1'b0; bus.di = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_overflow();
        test_empty_rdwr();
        test_full_rdwr();
        test_clear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
